// File: rtl/jtopl_mmr_q_pkg.sv
// Shared OPL register-map constants, write-queue entry layout and decode helpers.
package jtopl_mmr_q_pkg;

    // Global register addresses, shared with the OPL3 top level
    localparam logic [7:0] REG_TEST  = 8'h01;
    localparam logic [7:0] REG_CLKA  = 8'h02;
    localparam logic [7:0] REG_CLKB  = 8'h03;
    localparam logic [7:0] REG_TIMER = 8'h04;
    localparam logic [7:0] REG_CSM   = 8'h08;
    localparam logic [7:0] REG_BD    = 8'hBD;
    localparam logic [7:0] REG_4OP   = 8'h04;
    localparam logic [7:0] REG_NEW   = 8'h05;

    // One queued CPU data write, captured together with the index in force at push time
    typedef struct packed {
        logic       bank;
        logic [7:0] rg;
        logic [7:0] data;
    } wrq_entry_t;

    // Which update strobe a decoded entry raises
    typedef enum logic [2:0] {
        UP_NONE,
        UP_MULT,
        UP_KSL_TL,
        UP_AR_DR,
        UP_SL_RR,
        UP_WAV,
        UP_FNUM,
        UP_FBCON
    } up_kind_e;

    // Slot register family from the top three address bits
    function automatic up_kind_e slot_kind(input logic [2:0] hi);
        case (hi)
            3'd1:    return UP_MULT;
            3'd2:    return UP_KSL_TL;
            3'd3:    return UP_AR_DR;
            3'd4:    return UP_SL_RR;
            3'd7:    return UP_WAV;
            default: return UP_NONE;
        endcase
    endfunction

    // Slot registers: 0x20-0x95 and 0xE0-0xF5 with a valid subslot and group
    function automatic logic is_slot_reg(input logic [7:0] rg);
        return (rg[2:0] <= 3'd5) && (rg[4:3] != 2'd3) && (slot_kind(rg[7:5]) != UP_NONE);
    endfunction

    // Channel registers: 0xA0-0xA8, 0xB0-0xB8, 0xC0-0xC8
    function automatic logic is_chan_reg(input logic [7:0] rg);
        return (rg[3:0] <= 4'd8) && (rg[7:4] >= 4'hA) && (rg[7:4] <= 4'hC);
    endfunction

    // Channel number divided by three
    function automatic logic [1:0] chan_group(input logic [3:0] ch);
        if (ch < 4'd3)      return 2'd0;
        else if (ch < 4'd6) return 2'd1;
        else                return 2'd2;
    endfunction

    // Subslot that carries the channel settings within its group
    function automatic logic [2:0] chan_sub(input logic [3:0] ch);
        if (ch < 4'd6) return ch[2:0];
        else           return {1'b0, ~&ch[2:1], ch[0]};
    endfunction

endpackage

// File: rtl/jtopl_mmr_q_if.sv
// CPU-side bus of the register front end: data, strobe, address and queue-full flag.
interface jtopl_mmr_q_if;
    logic [7:0] din;
    logic       write;
    logic [1:0] addr;
    logic       busy;

    modport master (output din, output write, output addr, input busy);
    modport slave  (input din, input write, input addr, output busy);
endinterface

// File: rtl/jtopl_div.sv
// Operator tick generator: one cenop for every DIV chip clock enables.
module jtopl_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    output logic cenop
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Count chip enables, wrapping after DIV of them
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cen) begin
            cnt <= (cnt == LAST) ? '0 : cnt + ONE;
        end
    end

    assign cenop = cen && (cnt == '0);
endmodule

// File: rtl/jtopl_wrq.sv
// Small synchronous FIFO holding CPU data writes until the next operator tick.
module jtopl_wrq #(
    parameter int QDEPTH = 4,
    parameter int W      = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(QDEPTH);

    logic [W-1:0]  mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; a push into a full queue rides on a same-cycle pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/jtopl_mmr_q.sv
// OPL2/OPL3 memory-mapped register front end: queued CPU writes decoded once per operator tick.
module jtopl_mmr_q
    import jtopl_mmr_q_pkg::*;
#(
    parameter int BANKS  = 1,
    parameter int QDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    output logic            cenop,
    jtopl_mmr_q_if.slave    bus,
    output logic            sel_bank,
    output logic [1:0]      sel_group,
    output logic [2:0]      sel_sub,
    output logic [7:0]      data_out,
    output logic [7:0]      latch_fnum,
    output logic            up_mult,
    output logic            up_ksl_tl,
    output logic            up_ar_dr,
    output logic            up_sl_rr,
    output logic            up_wav,
    output logic            up_fnum,
    output logic            up_fbcon,
    output logic [7:0]      value_A,
    output logic [7:0]      value_B,
    output logic            load_A,
    output logic            load_B,
    output logic            flagen_A,
    output logic            flagen_B,
    output logic            clr_flag_A,
    output logic            clr_flag_B,
    output logic            am_dep,
    output logic            vib_dep,
    output logic            wav_en,
    output logic            csm,
    output logic            note_sel,
    output logic            opl3_en,
    output logic [5:0]      con4op
);
    logic [7:0]      selreg;
    logic            selbank;
    wrq_entry_t      push_entry;
    wrq_entry_t      pop_entry;
    logic            q_push;
    logic            q_pop;
    logic            q_full;
    logic            q_empty;
    logic [1:0][7:0] latch;
    logic            discard;
    up_kind_e        kind;

    jtopl_div u_div (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .cenop (cenop)
    );

    assign q_push     = bus.write && bus.addr[0];
    assign q_pop      = cenop;
    assign push_entry = '{bank: selbank, rg: selreg, data: bus.din};
    assign bus.busy   = q_full;

    jtopl_wrq #(
        .QDEPTH (QDEPTH),
        .W      ($bits(wrq_entry_t))
    ) u_wrq (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .din   (push_entry),
        .dout  (pop_entry),
        .full  (q_full),
        .empty (q_empty)
    );

    // Index port: register and bank selection take effect at once, outside the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            selreg  <= '0;
            selbank <= 1'b0;
        end else if (bus.write && !bus.addr[0]) begin
            selreg  <= bus.din;
            selbank <= bus.addr[1] && (BANKS == 2);
        end
    end

    // Classify the entry at the head of the queue
    always_comb begin
        discard = pop_entry.bank && !opl3_en &&
                  (pop_entry.rg != REG_4OP) && (pop_entry.rg != REG_NEW);
        kind = UP_NONE;
        if (is_slot_reg(pop_entry.rg)) begin
            kind = slot_kind(pop_entry.rg[7:5]);
        end else if (is_chan_reg(pop_entry.rg)) begin
            if (pop_entry.rg[7:4] == 4'hB)      kind = UP_FNUM;
            else if (pop_entry.rg[7:4] == 4'hC) kind = UP_FBCON;
        end
    end

    // Decode one entry per operator tick; strobes last exactly one tick
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_bank   <= 1'b0;
            sel_group  <= '0;
            sel_sub    <= '0;
            data_out   <= '0;
            latch_fnum <= '0;
            latch      <= '0;
            up_mult    <= 1'b0;
            up_ksl_tl  <= 1'b0;
            up_ar_dr   <= 1'b0;
            up_sl_rr   <= 1'b0;
            up_wav     <= 1'b0;
            up_fnum    <= 1'b0;
            up_fbcon   <= 1'b0;
            value_A    <= '0;
            value_B    <= '0;
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            flagen_A   <= 1'b1;
            flagen_B   <= 1'b1;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            am_dep     <= 1'b0;
            vib_dep    <= 1'b0;
            wav_en     <= 1'b0;
            csm        <= 1'b0;
            note_sel   <= 1'b0;
            opl3_en    <= 1'b0;
            con4op     <= '0;
        end else if (cenop) begin
            up_mult    <= 1'b0;
            up_ksl_tl  <= 1'b0;
            up_ar_dr   <= 1'b0;
            up_sl_rr   <= 1'b0;
            up_wav     <= 1'b0;
            up_fnum    <= 1'b0;
            up_fbcon   <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (!q_empty && !discard) begin
                sel_bank <= pop_entry.bank;
                data_out <= pop_entry.data;
                if (!pop_entry.bank) begin
                    case (pop_entry.rg)
                        REG_TEST: wav_en  <= pop_entry.data[5];
                        REG_CLKA: value_A <= pop_entry.data;
                        REG_CLKB: value_B <= pop_entry.data;
                        REG_TIMER: begin
                            if (pop_entry.data[7]) begin
                                clr_flag_A <= 1'b1;
                                clr_flag_B <= 1'b1;
                            end else begin
                                flagen_A <= ~pop_entry.data[6];
                                flagen_B <= ~pop_entry.data[5];
                                load_A   <= pop_entry.data[0];
                                load_B   <= pop_entry.data[1];
                            end
                        end
                        REG_CSM: begin
                            csm      <= pop_entry.data[7];
                            note_sel <= pop_entry.data[6];
                        end
                        REG_BD: begin
                            am_dep  <= pop_entry.data[7];
                            vib_dep <= pop_entry.data[6];
                        end
                        default: ;
                    endcase
                end else if (BANKS == 2) begin
                    case (pop_entry.rg)
                        REG_4OP: con4op  <= pop_entry.data[5:0];
                        REG_NEW: opl3_en <= pop_entry.data[0];
                        default: ;
                    endcase
                end
                if (is_slot_reg(pop_entry.rg)) begin
                    sel_group <= pop_entry.rg[4:3];
                    sel_sub   <= pop_entry.rg[2:0];
                end else if (is_chan_reg(pop_entry.rg)) begin
                    sel_group <= chan_group(pop_entry.rg[3:0]);
                    sel_sub   <= chan_sub(pop_entry.rg[3:0]);
                    if (pop_entry.rg[7:4] == 4'hA) latch[pop_entry.bank] <= pop_entry.data;
                    if (pop_entry.rg[7:4] == 4'hB) latch_fnum <= latch[pop_entry.bank];
                end
                case (kind)
                    UP_MULT:   up_mult   <= 1'b1;
                    UP_KSL_TL: up_ksl_tl <= 1'b1;
                    UP_AR_DR:  up_ar_dr  <= 1'b1;
                    UP_SL_RR:  up_sl_rr  <= 1'b1;
                    UP_WAV:    up_wav    <= 1'b1;
                    UP_FNUM:   up_fnum   <= 1'b1;
                    UP_FBCON:  up_fbcon  <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtopl_mmr_q.sv
// Directed bench for the OPL register front end (OPL3 configuration, four-entry queue).
module tb_jtopl_mmr_q;
    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       cenop;
    logic       sel_bank;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [7:0] data_out;
    logic [7:0] latch_fnum;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnum, up_fbcon;
    logic [7:0] value_A, value_B;
    logic       load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B;
    logic       am_dep, vib_dep, wav_en, csm, note_sel, opl3_en;
    logic [5:0] con4op;

    int vectors     = 0;
    int miscompares = 0;

    jtopl_mmr_q_if bus ();

    jtopl_mmr_q #(
        .BANKS  (2),
        .QDEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .cenop      (cenop),
        .bus        (bus),
        .sel_bank   (sel_bank),
        .sel_group  (sel_group),
        .sel_sub    (sel_sub),
        .data_out   (data_out),
        .latch_fnum (latch_fnum),
        .up_mult    (up_mult),
        .up_ksl_tl  (up_ksl_tl),
        .up_ar_dr   (up_ar_dr),
        .up_sl_rr   (up_sl_rr),
        .up_wav     (up_wav),
        .up_fnum    (up_fnum),
        .up_fbcon   (up_fbcon),
        .value_A    (value_A),
        .value_B    (value_B),
        .load_A     (load_A),
        .load_B     (load_B),
        .flagen_A   (flagen_A),
        .flagen_B   (flagen_B),
        .clr_flag_A (clr_flag_A),
        .clr_flag_B (clr_flag_B),
        .am_dep     (am_dep),
        .vib_dep    (vib_dep),
        .wav_en     (wav_en),
        .csm        (csm),
        .note_sel   (note_sel),
        .opl3_en    (opl3_en),
        .con4op     (con4op)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One-clk bus access, entered and left on a falling edge
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        bus.addr  = a;
        bus.din   = d;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic writeReg(input logic bank, input logic [7:0] rg, input logic [7:0] d);
        applyStimulus({bank, 1'b0}, rg);
        applyStimulus({bank, 1'b1}, d);
    endtask

    // n chip enables; only the first may be an operator tick
    task automatic cenPulses(input int n, input logic firstIsOp);
        for (int i = 0; i < n; i++) begin
            cen = 1'b1;
            #1;
            checkOutput("cenop", cenop, (i == 0) && firstIsOp);
            @(negedge clk);
        end
        cen = 1'b0;
    endtask

    task automatic opTick();
        cenPulses(4, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        cen       = 1'b0;
        bus.din   = '0;
        bus.addr  = '0;
        bus.write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_value_A", value_A, 0);
        checkOutput("rst_flagen_A", flagen_A, 1);
        checkOutput("rst_flagen_B", flagen_B, 1);
        checkOutput("rst_con4op", con4op, 0);
        checkOutput("rst_opl3_en", opl3_en, 0);

        // Timer A preload then load both timers
        writeReg(0, 8'h02, 8'h5A);
        writeReg(0, 8'h04, 8'h03);
        opTick();
        checkOutput("value_A", value_A, 8'h5A);
        checkOutput("load_A_early", load_A, 0);
        checkOutput("data_out_5A", data_out, 8'h5A);
        opTick();
        checkOutput("load_A", load_A, 1);
        checkOutput("load_B", load_B, 1);
        checkOutput("flagen_A_kept", flagen_A, 1);
        checkOutput("flagen_B_kept", flagen_B, 1);

        // Overfill: five back-to-back data writes, the fifth is dropped
        applyStimulus(2'b00, 8'h03);
        applyStimulus(2'b01, 8'h11);
        applyStimulus(2'b01, 8'h22);
        applyStimulus(2'b01, 8'h33);
        checkOutput("busy_3", bus.busy, 0);
        applyStimulus(2'b01, 8'h44);
        checkOutput("busy_4", bus.busy, 1);
        applyStimulus(2'b01, 8'h55);
        checkOutput("busy_5", bus.busy, 1);
        opTick();
        checkOutput("pop1_value_B", value_B, 8'h11);
        checkOutput("pop1_busy", bus.busy, 0);
        opTick();
        checkOutput("pop2_value_B", value_B, 8'h22);
        opTick();
        checkOutput("pop3_value_B", value_B, 8'h33);
        opTick();
        checkOutput("pop4_value_B", value_B, 8'h44);
        opTick();
        checkOutput("pop5_value_B", value_B, 8'h44);
        checkOutput("pop5_data_out", data_out, 8'h44);

        // Push into a full queue on a pop cycle is accepted
        applyStimulus(2'b01, 8'h61);
        applyStimulus(2'b01, 8'h62);
        applyStimulus(2'b01, 8'h63);
        applyStimulus(2'b01, 8'h64);
        cen       = 1'b1;
        bus.addr  = 2'b01;
        bus.din   = 8'h65;
        bus.write = 1'b1;
        #1;
        checkOutput("fullpop_cenop", cenop, 1);
        checkOutput("fullpop_busy", bus.busy, 1);
        @(negedge clk);
        bus.write = 1'b0;
        cen       = 1'b0;
        cenPulses(3, 1'b0);
        checkOutput("fullpop_value_B", value_B, 8'h61);
        checkOutput("fullpop_busy_after", bus.busy, 1);
        repeat (4) opTick();
        checkOutput("fullpop_last", value_B, 8'h65);
        checkOutput("fullpop_drained", bus.busy, 0);

        // F-number latch then block/key-on write
        writeReg(0, 8'hA3, 8'h44);
        writeReg(0, 8'hB3, 8'h31);
        opTick();
        checkOutput("fnumA_no_strobe", up_fnum, 0);
        opTick();
        checkOutput("up_fnum", up_fnum, 1);
        checkOutput("latch_fnum", latch_fnum, 8'h44);
        checkOutput("fnum_group", sel_group, 1);
        checkOutput("fnum_sub", sel_sub, 3);
        checkOutput("fnum_data", data_out, 8'h31);
        opTick();
        checkOutput("up_fnum_cleared", up_fnum, 0);

        // Channel 7 feedback/connection maps to group 2, subslot 1
        writeReg(0, 8'hC7, 8'h0F);
        opTick();
        checkOutput("up_fbcon", up_fbcon, 1);
        checkOutput("fbcon_group", sel_group, 2);
        checkOutput("fbcon_sub", sel_sub, 1);

        // Slot register and an invalid subslot address
        writeReg(0, 8'h4D, 8'h3F);
        opTick();
        checkOutput("up_ksl_tl", up_ksl_tl, 1);
        checkOutput("up_fbcon_cleared", up_fbcon, 0);
        checkOutput("ksl_group", sel_group, 1);
        checkOutput("ksl_sub", sel_sub, 5);
        writeReg(0, 8'h46, 8'h77);
        opTick();
        checkOutput("bad_sub_strobe", up_ksl_tl, 0);
        checkOutput("bad_sub_data", data_out, 8'h77);
        checkOutput("bad_sub_sub", sel_sub, 5);

        // Flag reset pulse leaves the timer controls alone
        writeReg(0, 8'h04, 8'hE3);
        opTick();
        checkOutput("clr_flag_A", clr_flag_A, 1);
        checkOutput("clr_flag_B", clr_flag_B, 1);
        checkOutput("clr_flagen_A", flagen_A, 1);
        checkOutput("clr_load_A", load_A, 1);
        opTick();
        checkOutput("clr_flag_A_end", clr_flag_A, 0);

        // Global mode bits
        writeReg(0, 8'hBD, 8'hC0);
        opTick();
        checkOutput("am_dep", am_dep, 1);
        checkOutput("vib_dep", vib_dep, 1);
        writeReg(0, 8'h08, 8'h40);
        opTick();
        checkOutput("csm", csm, 0);
        checkOutput("note_sel", note_sel, 1);
        writeReg(0, 8'h01, 8'h20);
        opTick();
        checkOutput("wav_en", wav_en, 1);

        // Bank 1 gated until OPL3 mode is enabled
        writeReg(1, 8'hE0, 8'h05);
        opTick();
        checkOutput("gated_up_wav", up_wav, 0);
        checkOutput("gated_sel_bank", sel_bank, 0);
        checkOutput("gated_data_out", data_out, 8'h20);
        writeReg(1, 8'h05, 8'h01);
        opTick();
        checkOutput("opl3_en", opl3_en, 1);
        checkOutput("new_sel_bank", sel_bank, 1);
        writeReg(1, 8'hE0, 8'h02);
        opTick();
        checkOutput("b1_up_wav", up_wav, 1);
        checkOutput("b1_sel_bank", sel_bank, 1);
        checkOutput("b1_sel_group", sel_group, 0);
        checkOutput("b1_sel_sub", sel_sub, 0);
        writeReg(1, 8'h04, 8'h15);
        opTick();
        checkOutput("con4op", con4op, 6'h15);
        checkOutput("b1_up_wav_end", up_wav, 0);

        // Reset with three entries queued
        writeReg(0, 8'h20, 8'h01);
        applyStimulus(2'b01, 8'h02);
        applyStimulus(2'b01, 8'h03);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_busy", bus.busy, 0);
        checkOutput("mid_rst_am_dep", am_dep, 0);
        checkOutput("mid_rst_opl3_en", opl3_en, 0);
        checkOutput("mid_rst_con4op", con4op, 0);
        checkOutput("mid_rst_value_A", value_A, 0);
        checkOutput("mid_rst_load_A", load_A, 0);
        checkOutput("mid_rst_flagen_B", flagen_B, 1);
        checkOutput("mid_rst_sel_bank", sel_bank, 0);
        checkOutput("mid_rst_latch_fnum", latch_fnum, 0);
        opTick();
        checkOutput("mid_rst_up_mult", up_mult, 0);
        checkOutput("mid_rst_data_out", data_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
